updown_counter_mod: RTL and testbench

- Parametrised up/down counter, successor to the fixed 4-bit up/down counter in the Tiny Tapeout top.
- Adds: configurable width, runtime modulo limit, wrap or saturate mode, synchronous clear/load, count enable, registered terminal-count pulse and sticky overflow flag.
- Instantiated inside the tt_um_* top; ui_in/uio_in drive the controls, uo_out shows the count and flags.

---
 rtl/updown_counter_mod_pkg.sv | 12 +
 rtl/updown_counter_mod_if.sv | 29 ++
 rtl/updown_counter_mod_next.sv | 37 +++
 rtl/updown_counter_mod.sv | 65 ++++++
 tb/tb_updown_counter_mod.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/updown_counter_mod_pkg.sv
// Shared constants for the parametrised up/down counter.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter_mod_if.sv
// Control and status bundle for updown_counter_mod; no handshake, every signal is
// sampled or updated on each rising clk edge.
interface updown_counter_mod_if import counter_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             en;
  logic             up;
  logic             sat_mode;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] max_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf_sticky;

  modport master (
    output en, up, sat_mode, clear, load, load_val, max_val, clr_ovf,
    input  count, tc, ovf_sticky
  );

  modport slave (
    input  en, up, sat_mode, clear, load, load_val, max_val, clr_ovf,
    output count, tc, ovf_sticky
  );

endinterface

// File: rtl/updown_counter_mod_next.sv
// Combinational next-value logic for one enabled step of the counter.
module counter_next import counter_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] max_val,
  input  logic             up,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] next_count,
  output logic             boundary_hit
);

  always_comb begin
    next_count   = count;
    boundary_hit = 1'b0;
    if (up == DIR_UP) begin
      // count above max_val counts as being at the top boundary
      if (count >= max_val) begin
        boundary_hit = 1'b1;
        next_count   = (sat_mode == MODE_SAT) ? max_val : '0;
      end else begin
        next_count = count + 1'b1;
      end
    end else begin
      // a lowered limit pulls count back into range without a boundary event
      if (count > max_val) begin
        next_count = max_val;
      end else if (count == '0) begin
        boundary_hit = 1'b1;
        next_count   = (sat_mode == MODE_SAT) ? '0 : max_val;
      end else begin
        next_count = count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with runtime modulo limit, wrap/saturate mode, clear/load,
// registered terminal-count pulse and sticky overflow flag.
module updown_counter_mod import counter_pkg::*; #(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                clk,
  input logic                rst_n,
  updown_counter_mod_if.slave bus
);

  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             ovf_q;
  logic [WIDTH-1:0] step_count;
  logic             step_boundary;
  logic [WIDTH-1:0] load_clamped;
  logic             boundary_event;

  counter_next #(.WIDTH(WIDTH)) u_next (
    .count        (count_q),
    .max_val      (bus.max_val),
    .up           (bus.up),
    .sat_mode     (bus.sat_mode),
    .next_count   (step_count),
    .boundary_hit (step_boundary)
  );

  assign load_clamped   = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
  assign boundary_event = !bus.clear && !bus.load && bus.en && step_boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
    end else if (bus.clear) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else if (bus.load) begin
      count_q <= load_clamped;
      tc_q    <= 1'b0;
    end else if (bus.en) begin
      count_q <= step_count;
      tc_q    <= step_boundary;
    end else begin
      tc_q    <= 1'b0;
    end
  end

  // a boundary event in the same cycle as clr_ovf keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (boundary_event) begin
      ovf_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.count      = count_q;
  assign bus.tc         = tc_q;
  assign bus.ovf_sticky = ovf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: directed scenarios plus randomized traffic,
// checked every cycle against an integer reference model.
module tb_updown_counter_mod;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  bit   chk_en;

  updown_counter_mod_if #(.WIDTH(W)) bus ();

  updown_counter_mod #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: integer arithmetic straight from the counting rules
  int m_count;
  bit m_tc;
  bit m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count <= 0;
      m_tc    <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin : mdl
      int c;
      int mx;
      bit t;
      c  = m_count;
      mx = int'(bus.max_val);
      t  = 1'b0;
      if (bus.clear) c = 0;
      else if (bus.load) c = (int'(bus.load_val) > mx) ? mx : int'(bus.load_val);
      else if (bus.en) begin
        if (bus.up) begin
          if (c >= mx) begin t = 1'b1; c = bus.sat_mode ? mx : 0; end
          else c = c + 1;
        end else begin
          if (c > mx) c = mx;
          else if (c == 0) begin t = 1'b1; c = bus.sat_mode ? 0 : mx; end
          else c = c - 1;
        end
      end
      m_count <= c;
      m_tc    <= t;
      if (t) m_ovf <= 1'b1;
      else if (bus.clr_ovf) m_ovf <= 1'b0;
    end
  end

  // scoreboard compare, every cycle out of reset
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("model_count", int'(bus.count), m_count);
      check("model_tc", int'(bus.tc), int'(m_tc));
      check("model_ovf", int'(bus.ovf_sticky), int'(m_ovf));
    end
  end

  // driver tasks
  task automatic step(input bit c, input bit l, input bit e, input bit u, input bit s,
                      input bit co, input int lv, input int mv);
    @(negedge clk);
    bus.clear    = c;
    bus.load     = l;
    bus.en       = e;
    bus.up       = u;
    bus.sat_mode = s;
    bus.clr_ovf  = co;
    bus.load_val = W'(lv);
    bus.max_val  = W'(mv);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.clear    = 1'b0;
    bus.load     = 1'b0;
    bus.en       = 1'b0;
    bus.up       = 1'b1;
    bus.sat_mode = 1'b0;
    bus.clr_ovf  = 1'b0;
    bus.load_val = '0;
    bus.max_val  = W'(9);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect3(input string tag, input int c, input int t, input int o);
    check({tag, "_count"}, int'(bus.count), c);
    check({tag, "_tc"}, int'(bus.tc), t);
    check({tag, "_ovf"}, int'(bus.ovf_sticky), o);
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    chk_en = 1'b1;
    do_reset();
    expect3("reset", 0, 0, 0);

    // wrap up through max_val=9
    for (int i = 1; i <= 9; i++) step(0, 0, 1, 1, 0, 0, 0, 9);
    expect3("wrap_at9", 9, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 9);
    expect3("wrap_to0", 0, 1, 1);
    step(0, 0, 1, 1, 0, 0, 0, 9);
    expect3("wrap_after", 1, 0, 1);

    // asynchronous reset mid-count
    do_reset();
    for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 0, 0, 0, 9);
    check("pre_reset_count", int'(bus.count), 7);
    #2 rst_n = 1'b0;
    #1 expect3("async_reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // saturate down from 2
    step(0, 1, 0, 0, 1, 0, 2, 9);
    check("load2", int'(bus.count), 2);
    step(0, 0, 1, 0, 1, 0, 0, 9);
    expect3("sat_dn1", 1, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0, 9);
    expect3("sat_dn0", 0, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0, 9);
    expect3("sat_hold_a", 0, 1, 1);
    step(0, 0, 1, 0, 1, 0, 0, 9);
    expect3("sat_hold_b", 0, 1, 1);

    // priority and load clamp
    step(1, 1, 1, 1, 0, 0, 5, 9);
    check("prio_clear", int'(bus.count), 0);
    check("prio_tc", int'(bus.tc), 0);
    step(0, 1, 1, 1, 0, 0, 12, 9);
    check("load_clamp", int'(bus.count), 9);

    // runtime limit lowered below count
    step(0, 1, 0, 0, 0, 0, 8, 9);
    step(0, 0, 1, 0, 0, 0, 0, 3);
    check("limit_pull", int'(bus.count), 3);
    check("limit_pull_tc", int'(bus.tc), 0);
    step(0, 0, 1, 1, 0, 0, 0, 3);
    check("limit_wrap", int'(bus.count), 0);
    check("limit_wrap_tc", int'(bus.tc), 1);

    // sticky clear, then clear colliding with a boundary step
    step(0, 0, 0, 1, 0, 1, 0, 3);
    expect3("clr_ovf", 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0, 3);
    expect3("clr_vs_set", 3, 1, 1);

    // max_val=0 pins count, every enabled step is a boundary
    step(0, 1, 0, 0, 0, 1, 5, 0);
    expect3("max0_load", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, i[0], i[1], 0, 0, 0);
      check("max0_count", int'(bus.count), 0);
      check("max0_tc", int'(bus.tc), 1);
    end

    // full-range wrap behaves like a plain binary counter
    step(0, 1, 0, 0, 0, 0, 14, 15);
    step(0, 0, 1, 1, 0, 0, 0, 15);
    step(0, 0, 1, 1, 0, 0, 0, 15);
    expect3("bin_wrap", 0, 1, 1);

    // randomized traffic, checked by the model every cycle
    begin
      int mv;
      mv = 9;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(15) == 0) mv = $urandom_range(15);
        step($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
             1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(7) == 0,
             $urandom_range(15), mv);
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
